ifetch_prefetch: RTL and testbench
==================================

IFETCH_PREFETCH -- requirements
Module: ifetch_prefetch

Interface
REQ-001 Parameter DEPTH, default 4: FIFO entries and maximum outstanding memory requests; power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 Ports, in order:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- redirect_valid  in  1  core requests fetch restart (branch/jump/exception).
- redirect_pc  in  32  new fetch address.
- mem_req  out  1  instruction-memory read request.
- mem_addr  out  32  word-aligned request address.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data returned; responses arrive in request order, at least 1 cycle after grant.
- mem_rdata  in  32  returned instruction word.
- instr_valid  out  1  head entry valid toward core.
- instr  out  32  head instruction.
- pc_current  out  32  address of head instruction.
- instr_ready  in  1  core consumes head this cycle.

Function
REQ-004 Fetch PC register issues mem_req=1 whenever (fifo_count + outstanding) < DEPTH and no redirect this cycle.
REQ-005 mem_addr = fetch PC; on mem_req & mem_gnt, fetch PC += 4, outstanding += 1.
REQ-006 Fetch PC wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no special action.
REQ-007 mem_req and mem_addr hold stable until granted, unless redirect.
REQ-008 On mem_rvalid (not discarded), {mem_rdata, request PC} is written into the FIFO; outstanding -= 1; visible on instr/pc_current the next cycle (1-cycle latency).
REQ-009 FIFO is first-word-fall-through: instr_valid=1 iff count>0; instr/pc_current show head.
REQ-010 Pop on instr_valid & instr_ready; instr_ready with empty FIFO is ignored.
REQ-011 Simultaneous push and pop on a full FIFO is legal; count unchanged.
REQ-012 Redirect: next cycle FIFO empty, fetch PC = {redirect_pc[31:2], 2'b00}, all outstanding responses (including one granted in the redirect cycle) counted into a discard counter and dropped on arrival.
REQ-013 Redirect beats simultaneous pop, push and grant; instr_valid=0 the cycle after redirect.
REQ-014 New requests after redirect are issued while discards are pending; (fifo_count + outstanding + discard) < DEPTH still limits issue.
REQ-015 Two-state FSM: RUN (normal), FLUSH (discard>0); FLUSH -> RUN when last stale response dropped; stale responses never reach the FIFO.

Reset
REQ-016 While rst=0: mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=0, pc_current=0, counts=0, FSM=RUN.
REQ-017 Reset mid-transaction abandons all outstanding requests; responses arriving after release are not tracked (memory is reset with the core).
REQ-018 First mem_req asserts on the first clk edge after rst deasserts.

Configuration
REQ-019 Macro IFETCH_STATS_EN defined: extra output fetch_cnt [31:0], +1 per popped instruction, and redirect_cnt [15:0], +1 per redirect; both saturate; both reset to 0.
REQ-020 IFETCH_STATS_EN undefined: those ports and counters are absent; all other behaviour identical.

Structure
REQ-021 Shared package mips_pkg holds XLEN=32, INSTR_W=32, RESET_VECTOR, and the fetch FSM state typedef.
REQ-022 One sub-module, prefetch_fifo (parameterised data width and DEPTH, FWFT, count output); fetch/flush control stays in ifetch_prefetch.

Verification
REQ-023 Reset release, mem grants every cycle, rvalid 1 cycle later, instr_ready=1: pc_current sequence 0x0,0x4,0x8... with matching instr, one per cycle after initial latency.
REQ-024 instr_ready=0 for 10 cycles: exactly DEPTH requests issued, FIFO full, mem_req=0; release -> entries pop in order, no loss or duplication.
REQ-025 Redirect to 0x0000_1002 with 3 outstanding: those 3 responses dropped, next instr has pc_current=0x0000_1000.
REQ-026 Redirect same cycle as pop and grant: instr_valid=0 next cycle; granted response discarded; fetch resumes at redirect target.
REQ-027 Redirect to 0xFFFF_FFF8: pc_current 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-028 rst pulled low mid-burst: all outputs at reset values asynchronously; after release, fetch restarts at RESET_PC; with IFETCH_STATS_EN, counters read 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared fetch-side types and constants: datapath widths, reset vector and fetch FSM state.
package mips_pkg;

  localparam int XLEN = 32;
  localparam int INSTR_W = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic {
    FETCH_RUN   = 1'b0,
    FETCH_FLUSH = 1'b1
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_prefetch_if.sv
// Instruction-memory request/response bus plus the instruction handshake toward the core.
interface ifetch_prefetch_if;
  import mips_pkg::*;

  logic               mem_req;
  logic [XLEN-1:0]    mem_addr;
  logic               mem_gnt;
  logic               mem_rvalid;
  logic [INSTR_W-1:0] mem_rdata;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [XLEN-1:0]    pc_current;
  logic               instr_ready;

  modport master (
    output mem_req, mem_addr, instr_valid, instr, pc_current,
    input  mem_gnt, mem_rvalid, mem_rdata, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr, pc_current,
    output mem_gnt, mem_rvalid, mem_rdata, instr_ready
  );

endinterface

// File: rtl/ifetch_prefetch_fifo.sv
// First-word-fall-through FIFO holding {instruction, pc}; flush empties it in one cycle.
module prefetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign do_pop  = pop && (count_reg != '0);
  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign valid = (count_reg != '0);
  assign head  = valid ? mem_reg[rd_ptr_reg] : '0;
  assign count = count_reg;

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction prefetcher: issues sequential fetches, buffers responses, drops stale ones after redirect.
// Optional IFETCH_STATS_EN adds saturating fetch_cnt / redirect_cnt outputs.
module ifetch_prefetch
  import mips_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_VECTOR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  ifetch_prefetch_if.master  bus
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0]        fetch_cnt,
  output logic [15:0]        redirect_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SUM_W = CNT_W + 2;

  fetch_state_e           state_reg;
  fetch_state_e           state_next;
  logic [XLEN-1:0]        fetch_pc_reg;
  logic [XLEN-1:0]        fetch_pc_next;
  logic [XLEN-1:0]        resp_pc_reg;
  logic [XLEN-1:0]        resp_pc_next;
  logic [CNT_W-1:0]       outstanding_reg;
  logic [CNT_W-1:0]       outstanding_next;
  logic [CNT_W-1:0]       discard_reg;
  logic [CNT_W-1:0]       discard_next;
  logic                   run_en_reg;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_valid;
  logic [INSTR_W+XLEN-1:0] fifo_head;
  logic [SUM_W-1:0]       credit_used;
  logic [XLEN-1:0]        redirect_target;
  logic                   issue;
  logic                   resp_live;
  logic                   resp_drop;

  assign redirect_target = word_align(redirect_pc);
  assign credit_used     = SUM_W'(fifo_count) + SUM_W'(outstanding_reg) + SUM_W'(discard_reg);
  assign issue           = bus.mem_req && bus.mem_gnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= FETCH_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH_RUN:   if (discard_next != '0) state_next = FETCH_FLUSH;
      FETCH_FLUSH: if (discard_next == '0) state_next = FETCH_RUN;
      default:     state_next = FETCH_RUN;
    endcase
  end

  // Responses are in order, so while any discard is pending the arriving one is stale.
  always_comb begin
    bus.mem_req = 1'b0;
    resp_drop   = 1'b0;
    resp_live   = 1'b0;
    if (run_en_reg && !redirect_valid && (credit_used < SUM_W'(DEPTH))) begin
      bus.mem_req = 1'b1;
    end
    if (bus.mem_rvalid) begin
      if (state_reg == FETCH_FLUSH) begin
        resp_drop = 1'b1;
      end else if (outstanding_reg != '0) begin
        resp_live = 1'b1;
      end
    end
  end

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    resp_pc_next     = resp_pc_reg;
    outstanding_next = outstanding_reg;
    discard_next     = discard_reg;
    if (redirect_valid) begin
      fetch_pc_next    = redirect_target;
      resp_pc_next     = redirect_target;
      outstanding_next = '0;
      // Everything in flight becomes stale, minus whatever response lands right now.
      discard_next     = outstanding_reg + discard_reg - CNT_W'(resp_live || resp_drop);
    end else begin
      if (issue) begin
        fetch_pc_next = fetch_pc_reg + 32'd4;
      end
      if (resp_live) begin
        resp_pc_next = resp_pc_reg + 32'd4;
      end
      outstanding_next = outstanding_reg + CNT_W'(issue) - CNT_W'(resp_live);
      discard_next     = discard_reg - CNT_W'(resp_drop);
    end
  end

  // run_en_reg holds off the first request until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      run_en_reg      <= 1'b0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      resp_pc_reg     <= resp_pc_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
      run_en_reg      <= 1'b1;
    end
  end

  prefetch_fifo #(
    .WIDTH(INSTR_W + XLEN),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .flush    (redirect_valid),
    .push     (resp_live),
    .push_data({bus.mem_rdata, resp_pc_reg}),
    .pop      (bus.instr_ready && !redirect_valid),
    .head     (fifo_head),
    .valid    (fifo_valid),
    .count    (fifo_count)
  );

  assign bus.mem_addr    = fetch_pc_reg;
  assign bus.instr_valid = fifo_valid;
  assign bus.instr       = fifo_head[INSTR_W+XLEN-1:XLEN];
  assign bus.pc_current  = fifo_head[XLEN-1:0];

`ifdef IFETCH_STATS_EN
  logic [31:0] fetch_cnt_reg;
  logic [15:0] redirect_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_reg    <= '0;
      redirect_cnt_reg <= '0;
    end else begin
      if (fifo_valid && bus.instr_ready && !redirect_valid && (fetch_cnt_reg != '1)) begin
        fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
      end
      if (redirect_valid && (redirect_cnt_reg != '1)) begin
        redirect_cnt_reg <= redirect_cnt_reg + 16'd1;
      end
    end
  end

  assign fetch_cnt    = fetch_cnt_reg;
  assign redirect_cnt = redirect_cnt_reg;
`endif

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Bench for ifetch_prefetch: in-order memory model, expected-instruction queue, phase table and corner sequences.
module tb_ifetch_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          NVEC     = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  ifetch_prefetch_if bus();

`ifdef IFETCH_STATS_EN
  logic [31:0] fetch_cnt;
  logic [15:0] redirect_cnt;
`endif

  ifetch_prefetch #(
    .DEPTH(DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .bus           (bus)
`ifdef IFETCH_STATS_EN
    ,
    .fetch_cnt     (fetch_cnt),
    .redirect_cnt  (redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } sb_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } pend_t;

  typedef struct {
    int    rdy;       // 0, 1, or 2 = random
    int    gnt;       // 0, 1, or 2 = random
    int    lat;
    int    ncyc;
    int    exp_valid; // -1 = not checked
    int    exp_req;
    int    exp_sb;
    string name;
  } vec_t;

  sb_t         sb_q[$];
  pend_t       pend_q[$];
  vec_t        vecs[NVEC];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc_no = 0;
  int          lat = 1;
  int          pops_model = 0;
  int          redirs_model = 0;
  logic [31:0] exp_fetch = RESET_PC;
  logic        obs_valid;
  logic        obs_req;
  logic [31:0] obs_pc;
  logic [31:0] obs_instr;
  logic [31:0] obs_addr;
  bit          popped;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h1234, ~a[31:16]};
  endfunction

  function automatic logic pick(input int mode);
    if (mode == 2) return 1'($urandom_range(0, 1));
    return (mode != 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1 time unit later, update memory model and scoreboard.
  task automatic cycle(input logic rdy, input logic gnt, input logic redir, input logic [31:0] tgt);
    sb_t   e;
    pend_t p;
    @(negedge clk);
    bus.instr_ready = rdy;
    bus.mem_gnt     = gnt;
    redirect_valid  = redir;
    redirect_pc     = tgt;
    if (pend_q.size() > 0 && cyc_no >= pend_q[0].cyc + lat) begin
      p = pend_q.pop_front();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = p.data;
    end else begin
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = $urandom;
    end
    #1;
    obs_valid = bus.instr_valid;
    obs_req   = bus.mem_req;
    obs_pc    = bus.pc_current;
    obs_instr = bus.instr;
    obs_addr  = bus.mem_addr;
    popped    = 1'b0;
    if (!redir && obs_valid && rdy) begin
      popped = 1'b1;
      pops_model++;
      $display("[TB] cycle %0d pop pc=%h instr=%h", cyc_no, obs_pc, obs_instr);
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pop actual pc=%h required=no instruction", obs_pc);
      end else begin
        e = sb_q.pop_front();
        chk("pop_pc", obs_pc, e.pc);
        chk("pop_instr", obs_instr, e.data);
      end
    end
    if (obs_req && gnt) begin
      chk("req_addr", obs_addr, exp_fetch);
      p.cyc  = cyc_no;
      p.data = instr_of(obs_addr);
      pend_q.push_back(p);
      e.pc   = exp_fetch;
      e.data = instr_of(exp_fetch);
      sb_q.push_back(e);
      exp_fetch += 32'd4;
    end
    if (redir) begin
      sb_q.delete();
      exp_fetch = {tgt[31:2], 2'b00};
      redirs_model++;
    end
    cyc_no++;
  endtask

  task automatic do_reset();
    rst             = 1'b0;
    redirect_valid  = 1'b0;
    bus.mem_gnt     = 1'b0;
    bus.mem_rvalid  = 1'b0;
    bus.mem_rdata   = 32'h0;
    bus.instr_ready = 1'b0;
    repeat (3) @(posedge clk);
    pend_q.delete();
    sb_q.delete();
    exp_fetch    = RESET_PC;
    pops_model   = 0;
    redirs_model = 0;
    lat          = 1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("req_before_first_edge", 32'(bus.mem_req), 32'd0);
    chk("addr_before_first_edge", bus.mem_addr, RESET_PC);
  endtask

  task automatic startup_check();
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("first_req", 32'(obs_req), 32'd1);
    chk("first_addr", obs_addr, RESET_PC);
    chk("startup_valid0", 32'(obs_valid), 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("startup_valid1", 32'(obs_valid), 32'd0);
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      chk("stream_valid", 32'(obs_valid), 32'd1);
      chk("stream_pc", obs_pc, RESET_PC + 32'(4 * k));
    end
  endtask

  task automatic wait_pop(input string name, input logic [31:0] exp_pc);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      if (popped) begin
        seen = 1'b1;
        chk(name, obs_pc, exp_pc);
      end
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s actual=no pop within 20 cycles required=pc %h", name, exp_pc);
    end
  endtask

  initial begin
    logic [31:0] wrap_pcs [3];
    int          idx;

    vecs[0] = '{1, 1, 1, 20,  1,  1, -1, "steady"};
    vecs[1] = '{0, 1, 1, 10,  1,  0,  4, "backpressure"};
    vecs[2] = '{1, 0, 1, 10,  0,  1,  0, "drain"};
    vecs[3] = '{1, 1, 3, 20, -1, -1, -1, "latency3"};
    vecs[4] = '{2, 2, 2, 40, -1, -1, -1, "random"};
    vecs[5] = '{1, 0, 1, 12,  0,  1,  0, "final_drain"};

    do_reset();
    startup_check();

    for (int v = 0; v < NVEC; v++) begin
      lat = vecs[v].lat;
      for (int c = 0; c < vecs[v].ncyc; c++) begin
        cycle(pick(vecs[v].rdy), pick(vecs[v].gnt), 1'b0, 32'h0);
      end
      if (vecs[v].exp_valid >= 0) chk({vecs[v].name, "_valid"}, 32'(obs_valid), 32'(vecs[v].exp_valid));
      if (vecs[v].exp_req >= 0)   chk({vecs[v].name, "_req"}, 32'(obs_req), 32'(vecs[v].exp_req));
      if (vecs[v].exp_sb >= 0)    chk({vecs[v].name, "_inflight"}, 32'(sb_q.size()), 32'(vecs[v].exp_sb));
    end

    // Three requests left hanging, then redirect to an unaligned target.
    lat = 50;
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    chk("hanging_requests", 32'(pend_q.size()), 32'd3);
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_1002);
    chk("req_in_redirect_cycle", 32'(obs_req), 32'd0);
    lat = 1;
    wait_pop("redirect_first_pc", 32'h0000_1000);

    // Redirect coinciding with a pop and a grant.
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_2000);
    chk("valid_in_redirect_cycle", 32'(obs_valid), 32'd1);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("valid_after_redirect", 32'(obs_valid), 32'd0);
    wait_pop("redirect2_first_pc", 32'h0000_2000);

    // Fetch address wrap at the top of the address space.
    wrap_pcs[0] = 32'hFFFF_FFF8;
    wrap_pcs[1] = 32'hFFFF_FFFC;
    wrap_pcs[2] = 32'h0000_0000;
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    idx = 0;
    for (int i = 0; i < 30 && idx < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      if (popped) begin
        chk("wrap_pc", obs_pc, wrap_pcs[idx]);
        idx++;
      end
    end
    chk("wrap_pop_count", 32'(idx), 32'd3);

`ifdef IFETCH_STATS_EN
    chk("fetch_cnt", fetch_cnt, 32'(pops_model));
    chk("redirect_cnt", 32'(redirect_cnt), 32'(redirs_model));
`endif

    // Asynchronous reset in the middle of a burst.
    repeat (5) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("valid_before_async_reset", 32'(bus.instr_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, RESET_PC);
    chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_pc_current", bus.pc_current, 32'h0);
`ifdef IFETCH_STATS_EN
    chk("rst_fetch_cnt", fetch_cnt, 32'h0);
    chk("rst_redirect_cnt", 32'(redirect_cnt), 32'h0);
`endif
    do_reset();
    startup_check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=still running required=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
